// File: rtl/alu_writeback_stage.sv
// Purpose  : ALU execute/writeback stage; buffers ALU results in a 2-entry FIFO and retires them in order.
// Latency  : entry accepted at edge N drives rf_we in cycle N+1; status_flags/retired_cnt update after the retiring edge.
// Backpress: in_ready = FIFO not full; head (write class) holds with stable rf_waddr/rf_wdata while rf_ready=0.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake; in_opcode, in_dest, in_result, in_zf/cf/nf/of payload
//   rf_we/rf_waddr/rf_wdata      register-file write request, completed when rf_ready=1
//   status_flags                 architectural {Z,C,N,O}
//   retired_cnt                  retired-instruction count (wraps)
//   illegal_op                   sticky, set when an illegal opcode retires
// Optional: define ALU_WB_BYPASS_EN to add byp_valid/byp_addr/byp_data forwarding outputs.
module alu_writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W:0]       in_result,
    input  logic                  in_zf,
    input  logic                  in_cf,
    input  logic                  in_nf,
    input  logic                  in_of,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic                  rf_ready,
    output logic [3:0]            status_flags,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic                  illegal_op
`ifdef ALU_WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    typedef struct packed {
        logic [5:0]            opcode;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
        logic [3:0]            flags;   // {Z,C,N,O}
    } entry_t;

    function automatic logic is_write(input logic [5:0] op);
        return ((op >= 6'd9) && (op <= 6'd22)) || (op == 6'd25) || (op == 6'd26);
    endfunction

    function automatic logic is_flags_only(input logic [5:0] op);
        return (op == 6'd23) || (op == 6'd24);
    endfunction

    // Slot 0 is always the head; slot 1 is the second-oldest entry.
    entry_t           ent_q [2];
    entry_t           ent_d [2];
    logic [1:0]       count_q, count_d;
    logic [3:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    entry_t new_ent;
    logic   head_vld, head_wr, head_legal, push, pop;

    // The carry bit of the ALU result is not architecturally stored.
    logic unused_carry;
    assign unused_carry = in_result[DATA_W];

    always_comb begin
        new_ent    = '{opcode: in_opcode, dest: in_dest, data: in_result[DATA_W-1:0],
                       flags: {in_zf, in_cf, in_nf, in_of}};
        head_vld   = (count_q != 2'd0);
        head_wr    = is_write(ent_q[0].opcode);
        head_legal = head_wr || is_flags_only(ent_q[0].opcode);

        in_ready = (count_q != 2'd2);
        rf_we    = head_vld && head_wr;
        rf_waddr = rf_we ? ent_q[0].dest : '0;
        rf_wdata = rf_we ? ent_q[0].data : '0;

        // Flags-only and illegal heads retire without waiting on the register file.
        push = in_valid && in_ready;
        pop  = head_vld && (!head_wr || rf_ready);

        ent_d     = ent_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        status_d  = status_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;

        if (pop) begin
            ent_d[0] = ent_q[1];
            cnt_d    = cnt_q + CNT_W'(1);
            if (head_legal) begin
                status_d = ent_q[0].flags;
            end else begin
                illegal_d = 1'b1;
            end
        end

        // New entry lands behind whatever survives the pop.
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                ent_d[0] = new_ent;
            end else begin
                ent_d[1] = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q[0]  <= '0;
            ent_q[1]  <= '0;
            count_q   <= 2'd0;
            status_q  <= 4'b0000;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            ent_q[0]  <= ent_d[0];
            ent_q[1]  <= ent_d[1];
            count_q   <= count_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign status_flags = status_q;
    assign retired_cnt  = cnt_q;
    assign illegal_op   = illegal_q;

`ifdef ALU_WB_BYPASS_EN
    // Newest buffered write wins: tail (slot 1) when occupied, else head.
    // Forced to zero while rst is high so stale entries never forward.
    always_comb begin
        byp_valid = 1'b0;
        byp_addr  = '0;
        byp_data  = '0;
        if (!rst) begin
            if ((count_q == 2'd2) && is_write(ent_q[1].opcode)) begin
                byp_valid = 1'b1;
                byp_addr  = ent_q[1].dest;
                byp_data  = ent_q[1].data;
            end else if (head_vld && head_wr) begin
                byp_valid = 1'b1;
                byp_addr  = ent_q[0].dest;
                byp_data  = ent_q[0].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [2:0]  in_dest;
    logic [16:0] in_result;
    logic        in_zf, in_cf, in_nf, in_of;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [3:0]  status_flags;
    logic [15:0] retired_cnt;
    logic        illegal_op;
`ifdef ALU_WB_BYPASS_EN
    logic        byp_valid;
    logic [2:0]  byp_addr;
    logic [15:0] byp_data;
`endif

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_dest(in_dest), .in_result(in_result),
        .in_zf(in_zf), .in_cf(in_cf), .in_nf(in_nf), .in_of(in_of),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .status_flags(status_flags), .retired_cnt(retired_cnt), .illegal_op(illegal_op)
`ifdef ALU_WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
`endif
    );

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] d,
                         input logic [16:0] r, input logic [3:0] f);
        in_valid  = v;
        in_opcode = op;
        in_dest   = d;
        in_result = r;
        {in_zf, in_cf, in_nf, in_of} = f;
    endtask

    // Opcode classes written as plain range membership.
    function automatic bit m_is_write(input logic [5:0] op);
        return op inside {[6'd9:6'd22], [6'd25:6'd26]};
    endfunction
    function automatic bit m_is_legal(input logic [5:0] op);
        return m_is_write(op) || (op inside {6'd23, 6'd24});
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  dest;
        logic [16:0] res;
        logic [3:0]  flg;
        logic        e_we;
        logic [2:0]  e_waddr;
        logic [15:0] e_wdata;
        logic [3:0]  e_status;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  dest;
        logic [15:0] data;
        logic [3:0]  flg;
    } m_ent_t;

    vec_t   vecs [6];
    m_ent_t mq[$];

    initial begin
        vecs[0] = '{6'b001001, 3'd3, 17'h0_0013, 4'b0000, 1'b1, 3'd3, 16'h0013, 4'b0000};
        vecs[1] = '{6'b001001, 3'd1, 17'h1_0000, 4'b1100, 1'b1, 3'd1, 16'h0000, 4'b1100};
        vecs[2] = '{6'b010111, 3'd5, 17'h0_1234, 4'b0010, 1'b0, 3'd0, 16'h0000, 4'b0010};
        vecs[3] = '{6'b011000, 3'd6, 17'h0_0000, 4'b1000, 1'b0, 3'd0, 16'h0000, 4'b1000};
        vecs[4] = '{6'b011010, 3'd7, 17'h0_BEEF, 4'b0001, 1'b1, 3'd7, 16'hBEEF, 4'b0001};
        vecs[5] = '{6'b010110, 3'd2, 17'h1_8000, 4'b0010, 1'b1, 3'd2, 16'h8000, 4'b0010};

        rst = 1'b1;
        rf_ready = 1'b1;
        drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_waddr", rf_waddr, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset status", status_flags, 0);
        chk("reset cnt", retired_cnt, 0);
        chk("reset illegal", illegal_op, 0);
        rst = 1'b0;

        // Single-op vectors into an empty FIFO with rf_ready=1.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].dest, vecs[i].res, vecs[i].flg);
            @(negedge clk);
            drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
            chk($sformatf("vec%0d rf_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].e_waddr);
            chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            @(negedge clk);
            exp_cnt++;
            chk($sformatf("vec%0d status", i), status_flags, vecs[i].e_status);
            chk($sformatf("vec%0d cnt", i), retired_cnt, exp_cnt);
            chk($sformatf("vec%0d rf_we after", i), rf_we, 0);
        end

        // Backpressure: three back-to-back pushes with rf_ready low.
        @(negedge clk);
        rf_ready = 1'b0;
        drive(1'b1, 6'd9, 3'd1, 17'h0_1111, 4'b1000);
        chk("bp in_ready0", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 6'd10, 3'd2, 17'h0_2222, 4'b0100);
        chk("bp in_ready1", in_ready, 1);
        chk("bp waddr1", rf_waddr, 1);
        @(negedge clk);
        drive(1'b1, 6'd11, 3'd4, 17'h0_4444, 4'b0001);
        chk("bp in_ready full", in_ready, 0);
        chk("bp we held", rf_we, 1);
        chk("bp waddr held", rf_waddr, 1);
        chk("bp wdata held", rf_wdata, 16'h1111);
        @(negedge clk);
        chk("bp in_ready still full", in_ready, 0);
        chk("bp wdata stable", rf_wdata, 16'h1111);
        chk("bp status frozen", status_flags, 4'b0010);
        rf_ready = 1'b1;
        @(negedge clk);
        chk("bp 2nd waddr", rf_waddr, 2);
        chk("bp 2nd wdata", rf_wdata, 16'h2222);
        chk("bp in_ready back", in_ready, 1);
        chk("bp status 1st", status_flags, 4'b1000);
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
        chk("bp 3rd waddr", rf_waddr, 4);
        chk("bp 3rd wdata", rf_wdata, 16'h4444);
        chk("bp status 2nd", status_flags, 4'b0100);
        @(negedge clk);
        exp_cnt += 3;
        chk("bp drained we", rf_we, 0);
        chk("bp status 3rd", status_flags, 4'b0001);
        chk("bp cnt", retired_cnt, exp_cnt);

        // Illegal opcode after a SUB that set N.
        drive(1'b1, 6'd10, 3'd5, 17'h0_F000, 4'b0010);
        @(negedge clk);
        drive(1'b1, 6'd0, 3'd6, 17'h0_ABCD, 4'b1111);
        chk("ill sub we", rf_we, 1);
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
        chk("ill head no we", rf_we, 0);
        chk("ill head wdata", rf_wdata, 0);
        chk("ill status after sub", status_flags, 4'b0010);
        chk("ill not yet", illegal_op, 0);
        @(negedge clk);
        exp_cnt += 2;
        chk("ill status kept", status_flags, 4'b0010);
        chk("ill sticky set", illegal_op, 1);
        chk("ill cnt", retired_cnt, exp_cnt);
        drive(1'b1, 6'd12, 3'd3, 17'h0_0007, 4'b1001);
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
        @(negedge clk);
        exp_cnt++;
        chk("ill still sticky", illegal_op, 1);
        chk("ill legal status", status_flags, 4'b1001);
        chk("ill legal cnt", retired_cnt, exp_cnt);

        // Reset with two entries buffered and rf_ready low.
        rf_ready = 1'b0;
        drive(1'b1, 6'd9, 3'd1, 17'h0_5555, 4'b0100);
        @(negedge clk);
        drive(1'b1, 6'd9, 3'd2, 17'h0_6666, 4'b0100);
        @(negedge clk);
        drive(1'b0, 6'd0, 3'd0, 17'd0, 4'd0);
        chk("rst pre full", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rf_ready = 1'b1;
        chk("rst in_ready", in_ready, 1);
        chk("rst rf_we", rf_we, 0);
        chk("rst waddr", rf_waddr, 0);
        chk("rst status", status_flags, 0);
        chk("rst cnt", retired_cnt, 0);
        chk("rst illegal", illegal_op, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst no write %0d", i), rf_we, 0);
        end

        // Randomized traffic against a queue-based reference model.
        begin
            logic [3:0]  m_status = 4'b0000;
            logic [15:0] m_cnt    = 16'd0;
            logic        m_ill    = 1'b0;
            bit          stalled  = 0;
            bit          m_pop, m_push, m_we;
            int          r;
            mq.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                m_we = (mq.size() > 0) && m_is_write(mq[0].op);
                chk("rnd in_ready", in_ready, mq.size() < 2);
                chk("rnd rf_we", rf_we, m_we);
                chk("rnd rf_waddr", rf_waddr, m_we ? mq[0].dest : 3'd0);
                chk("rnd rf_wdata", rf_wdata, m_we ? mq[0].data : 16'd0);
                chk("rnd status", status_flags, m_status);
                chk("rnd cnt", retired_cnt, m_cnt);
                chk("rnd illegal", illegal_op, m_ill);

                if (!stalled) begin
                    logic [5:0] op;
                    r = $urandom_range(0, 19);
                    if (r < 12)      op = 6'($urandom_range(9, 22));
                    else if (r < 14) op = 6'($urandom_range(25, 26));
                    else if (r < 17) op = 6'($urandom_range(23, 24));
                    else             op = 6'($urandom_range(0, 63));
                    drive($urandom_range(0, 3) != 0, op, 3'($urandom), 17'($urandom),
                          4'($urandom));
                end
                rf_ready = ($urandom_range(0, 9) < 7);

                m_push  = in_valid && (mq.size() < 2);
                m_pop   = (mq.size() > 0) && (!m_is_write(mq[0].op) || rf_ready);
                stalled = in_valid && !m_push;
                if (m_pop) begin
                    m_cnt++;
                    if (m_is_legal(mq[0].op)) m_status = mq[0].flg;
                    else                      m_ill = 1'b1;
                    void'(mq.pop_front());
                end
                if (m_push) begin
                    mq.push_back('{in_opcode, in_dest, in_result[15:0],
                                   {in_zf, in_cf, in_nf, in_of}});
                end
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
